multiword_add_sequencer: RTL and testbench



---
 rtl/multiword_add_pkg.sv | 19 +
 rtl/N_bit_adder.sv | 36 +++
 rtl/multiword_add_sequencer_rr_arbiter.sv | 29 ++
 rtl/multiword_add_sequencer.sv | 176 +++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/multiword_add_pkg.sv
// Shared types and defaults for the multi-word add sequencer.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF     = 8;
  localparam int WORDS_DEF = 4;
  localparam int REQS_DEF  = 2;

  // Requester id width; a single requester still gets a 1-bit id.
  function automatic int id_width(input int reqs);
    return (reqs > 1) ? $clog2(reqs) : 1;
  endfunction

endpackage

// File: rtl/N_bit_adder.sv
// Existing N-bit ripple-carry adder datapath built from single-bit full adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module N_bit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[N];

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    full_adder u_fa (
      .a   (a[gi]),
      .b   (b[gi]),
      .cin (carry[gi]),
      .sum (sum[gi]),
      .cout(carry[gi+1])
    );
  end
endmodule

// File: rtl/multiword_add_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after rr_ptr.
module rr_arbiter #(
  parameter int REQS = 2,
  parameter int ID_W = 1
) (
  input  logic [REQS-1:0] req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [REQS-1:0] grant
);
  int   idx;
  logic found;

  // Walk rr_ptr, rr_ptr+1, ... (mod REQS) and grant the first valid requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < REQS; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= REQS) idx = idx - REQS;
      for (int r = 0; r < REQS; r++) begin
        if (!found && (r == idx) && req_valid[r]) begin
          grant[r] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-word add sequencer: shares one N-bit ripple adder between REQS requesters,
// adding one word per cycle LSW first with a registered inter-word carry.
// Optional macro ADDSUB_EN adds a per-requester req_sub input selecting A-B.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int REQS  = REQS_DEF,
  localparam int W    = N * WORDS,
  localparam int ID_W = id_width(REQS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQS-1:0]   req_valid,
  output logic [REQS-1:0]   req_ready,
  input  logic [REQS*W-1:0] req_a,
  input  logic [REQS*W-1:0] req_b,
  input  logic [REQS-1:0]   req_cin,
`ifdef ADDSUB_EN
  input  logic [REQS-1:0]   req_sub,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic [ID_W-1:0]   rsp_id
);
  localparam int K_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [K_W-1:0]  k_reg;
  logic            carry_reg;
  logic [W-1:0]    a_reg, b_reg;
  logic            sub_reg;
  logic            rsp_valid_reg, rsp_cout_reg;
  logic [W-1:0]    sum_reg, sum_next;
  logic [ID_W-1:0] rsp_id_reg;

  logic [REQS-1:0] grant;
  logic [ID_W-1:0] grant_id, rr_ptr_next;
  logic            accept;
  logic [W-1:0]    cap_a, cap_b;
  logic            cap_cin, cap_sub;
  logic [N-1:0]    a_word, b_raw, b_word, sum_word;
  logic            cout_word;

  rr_arbiter #(.REQS(REQS), .ID_W(ID_W)) u_arb (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr_reg),
    .grant    (grant)
  );

  assign req_ready   = (state_reg == IDLE) ? grant : '0;
  assign accept      = |(req_valid & req_ready);
  assign rr_ptr_next = (grant_id == ID_W'(REQS - 1)) ? '0 : grant_id + ID_W'(1);

  // Encode the grant and mux out the granted requester's operands.
  always_comb begin
    grant_id = '0;
    cap_a    = '0;
    cap_b    = '0;
    cap_cin  = 1'b0;
    cap_sub  = 1'b0;
    for (int r = 0; r < REQS; r++) begin
      if (grant[r]) begin
        grant_id = ID_W'(r);
        cap_a    = req_a[r*W +: W];
        cap_b    = req_b[r*W +: W];
        cap_cin  = req_cin[r];
`ifdef ADDSUB_EN
        cap_sub  = req_sub[r];
`endif
      end
    end
  end

  // Select the operand words for the current word index.
  always_comb begin
    a_word = '0;
    b_raw  = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (k_reg == K_W'(w)) begin
        a_word = a_reg[w*N +: N];
        b_raw  = b_reg[w*N +: N];
      end
    end
  end

  // Subtraction is A + ~B + 1: invert each B word; the +1 comes from the preset carry.
  assign b_word = b_raw ^ {N{sub_reg}};

  N_bit_adder #(.N(N)) u_adder (
    .a   (a_word),
    .b   (b_word),
    .cin (carry_reg),
    .sum (sum_word),
    .cout(cout_word)
  );

  // Merge the fresh sum word into its slot of the result.
  always_comb begin
    sum_next = sum_reg;
    for (int w = 0; w < WORDS; w++) begin
      if (k_reg == K_W'(w)) sum_next[w*N +: N] = sum_word;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: accept in IDLE, one word per cycle in RUN, hold in DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (k_reg == K_LAST) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: operand capture, word sequencing and response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      k_reg         <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sub_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      sum_reg       <= '0;
      rsp_cout_reg  <= 1'b0;
      rsp_id_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg      <= cap_a;
            b_reg      <= cap_b;
            sub_reg    <= cap_sub;
            carry_reg  <= cap_sub ? 1'b1 : cap_cin;
            rsp_id_reg <= grant_id;
            rr_ptr_reg <= rr_ptr_next;
            k_reg      <= '0;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= cout_word;
          if (k_reg == K_LAST) begin
            rsp_cout_reg  <= cout_word;
            rsp_valid_reg <= 1'b1;
          end else begin
            k_reg <= k_reg + K_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign rsp_id    = rsp_id_reg;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (N=8, WORDS=4, REQS=2).
// Define ADDSUB_EN to also exercise the subtract path.
module tb_multiword_add_sequencer;
  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int REQS  = 2;
  localparam int W     = N * WORDS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [REQS-1:0] req_valid;
  logic [REQS-1:0] req_ready;
  logic [REQS*W-1:0] req_a, req_b;
  logic [REQS-1:0] req_cin;
  logic [REQS-1:0] req_sub;
  logic            rsp_valid, rsp_ready;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic [0:0]      rsp_id;

  int vec_count  = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.N(N), .WORDS(WORDS), .REQS(REQS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
`ifdef ADDSUB_EN
    .req_sub  (req_sub),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .rsp_id   (rsp_id)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_cin[r]      = cin;
    req_sub[r]      = sub;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  // Single request on requester r with rsp_ready held high.
  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] es,
                        input logic ec, input int eid, input string tag);
    int n;
    logic [1:0] exp_ready;
    set_req(r, a, b, cin, sub);
    exp_ready = 2'b01 << r;
    req_valid = exp_ready;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
    tick();
    req_valid = '0;
    wait_rsp(n);
    check({tag, "_latency"}, 64'(n), 64'(WORDS));
    check({tag, "_sum"}, 64'(rsp_sum), 64'(es));
    check({tag, "_cout"}, 64'(rsp_cout), 64'(ec));
    check({tag, "_id"}, 64'(rsp_id), 64'(eid));
    $display("op %s: req=%0d a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b id=%0d lat=%0d",
             tag, r, a, b, cin, sub, rsp_sum, rsp_cout, rsp_id, n);
    tick();
    check({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int n, gap, eid;
    logic [31:0] es;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_sum", 64'(rsp_sum), 64'd0);
    check("reset_cout", 64'(rsp_cout), 64'd0);
    check("reset_id", 64'(rsp_id), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic add, then a carry through all four words; the second also skips requester 1.
    run_op(0, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 0, "add_ff_1");
    run_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 0, "carry_ripple");

    // Back-pressure in DONE while requester 1 waits.
    rsp_ready = 1'b0;
    set_req(0, 32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0);
    req_valid = 2'b01;
    #1;
    check("stall_ready", 64'(req_ready), 64'd1);
    tick();
    set_req(1, 32'h00000001, 32'h00000002, 1'b1, 1'b0);
    req_valid = 2'b10;
    wait_rsp(n);
    check("stall_latency", 64'(n), 64'd4);
    check("stall_sum", 64'(rsp_sum), 64'hDFAEBFF0);
    $display("op stall: req=0 sum=%h cout=%b id=%0d", rsp_sum, rsp_cout, rsp_id);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold_valid", 64'(rsp_valid), 64'd1);
      check("stall_hold_sum", 64'(rsp_sum), 64'hDFAEBFF0);
      check("stall_hold_id", 64'(rsp_id), 64'd0);
      check("stall_no_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("stall_release_valid", 64'(rsp_valid), 64'd0);
    #1;
    check("stall_next_ready", 64'(req_ready), 64'd2);
    tick();
    req_valid = '0;
    wait_rsp(n);
    check("stall_next_latency", 64'(n), 64'd4);
    check("stall_next_sum", 64'(rsp_sum), 64'h00000004);
    check("stall_next_cout", 64'(rsp_cout), 64'd0);
    check("stall_next_id", 64'(rsp_id), 64'd1);
    $display("op stall_next: req=1 sum=%h cout=%b id=%0d", rsp_sum, rsp_cout, rsp_id);
    tick();

    // Reset pulse while RUN is on word 2; the operation must vanish.
    set_req(0, 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("midrun_k", 64'(dut.k_reg), 64'd2);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", 64'(rsp_valid), 64'd0);
    check("midrun_rst_ptr", 64'(dut.rr_ptr_reg), 64'd0);
    check("midrun_rst_sum", 64'(rsp_sum), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      check("midrun_no_rsp", 64'(rsp_valid), 64'd0);
    end
    run_op(1, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1, "post_reset");

    // Both requesters valid: strict alternation, one accept every WORDS+2 cycles.
    set_req(0, 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    set_req(1, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_rsp(n);
      gap = (i == 0) ? n : n + 1;
      check("rr_gap", 64'(gap), (i == 0) ? 64'd5 : 64'd6);
      eid = i % 2;
      es  = (eid == 1) ? 32'h00000001 : 32'h23456789;
      check("rr_id", 64'(rsp_id), 64'(eid));
      check("rr_sum", 64'(rsp_sum), 64'(es));
      check("rr_cout", 64'(rsp_cout), 64'(eid));
      $display("op rr%0d: sum=%h cout=%b id=%0d gap=%0d", i, rsp_sum, rsp_cout, rsp_id, gap);
      if (i == 5) req_valid = '0;
      tick();
    end

`ifdef ADDSUB_EN
    run_op(0, 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 0, "sub_5_7");
    run_op(0, 32'd7, 32'd5, 1'b0, 1'b1, 32'h00000002, 1'b1, 0, "sub_7_5");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
